// File: rtl/soc_system_cpu_oci_dct_monitor_if.sv
// Trace-capture bundle for the OCI data-trace monitor: the frame-commit
// side (buffer, count, strobe) and the valid/ready read-out side.
interface soc_system_cpu_oci_dct_monitor_if #(
    parameter int FRAME_W = 30,
    parameter int COUNT_W = 4
);
    logic [FRAME_W-1:0]         dct_buffer;
    logic [COUNT_W-1:0]         dct_count;
    logic                       dct_valid;
    logic [COUNT_W+FRAME_W-1:0] rd_data;
    logic                       rd_valid;
    logic                       rd_ready;

    // Trace source and consumer side
    modport master (
        output dct_buffer, dct_count, dct_valid, rd_ready,
        input  rd_data, rd_valid
    );

    // Monitor side
    modport slave (
        input  dct_buffer, dct_count, dct_valid, rd_ready,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/soc_system_cpu_oci_dct_monitor.sv
// OCI data-trace capture monitor: checks each committed frame's slot count,
// queues legal frames in a first-word-fall-through FIFO with a registered
// head, counts dropped and malformed frames, and sequences an end-of-test
// flush (CAPTURE -> FLUSH -> DONE, or HALT from anywhere).
module soc_system_cpu_oci_dct_monitor #(
    parameter int FRAME_W = 30,
    parameter int COUNT_W = 4,
    parameter int SLOTS   = 3,
    parameter int DEPTH   = 16,
    parameter int OVF_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    soc_system_cpu_oci_dct_monitor_if.slave trace,
    input  logic                           test_ending,
    input  logic                           test_has_ended,
    output logic [$clog2(DEPTH):0]         fill,
    output logic [OVF_W-1:0]               overflow_cnt,
    output logic [OVF_W-1:0]               error_cnt,
    output logic [1:0]                     state,
    output logic                           done
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = COUNT_W + FRAME_W;

    localparam logic [PTR_W:0]       FILL_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]       FILL_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]       FILL_ZERO  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [COUNT_W-1:0]   COUNT_MAX  = COUNT_W'(SLOTS);
    localparam logic [COUNT_W-1:0]   COUNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [OVF_W-1:0]     CNT_MAX    = {OVF_W{1'b1}};
    localparam logic [OVF_W-1:0]     CNT_ONE    = OVF_W'(1);
    localparam logic [OVF_W-1:0]     CNT_ZERO   = {OVF_W{1'b0}};
    localparam logic [ENTRY_W-1:0]   ENTRY_ZERO = {ENTRY_W{1'b0}};

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_DONE    = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    state_e               state_r;
    state_e               state_next_s;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_next_s;
    logic [PTR_W:0]       fill_r;
    logic [PTR_W:0]       fill_next_s;
    logic [ENTRY_W-1:0]   rd_data_r;
    logic [ENTRY_W-1:0]   head_next_s;
    logic [ENTRY_W-1:0]   entry_s;
    logic                 rd_valid_r;
    logic                 done_r;
    logic [OVF_W-1:0]     ovf_cnt_r;
    logic [OVF_W-1:0]     err_cnt_r;
    logic [ENTRY_W-1:0]   mem_r [DEPTH];

    logic count_legal_s;
    logic capture_s;
    logic pop_s;
    logic push_s;
    logic err_hit_s;
    logic ovf_hit_s;

    assign entry_s       = {trace.dct_count, trace.dct_buffer};
    assign count_legal_s = (trace.dct_count != COUNT_ZERO) && (trace.dct_count <= COUNT_MAX);
    assign capture_s     = trace.dct_valid && (state_r == ST_CAPTURE);
    // rd_valid_r is already low in HALT, so pops are blocked there too
    assign pop_s         = rd_valid_r && trace.rd_ready;
    assign push_s        = capture_s && count_legal_s && ((fill_r != FILL_FULL) || pop_s);
    assign err_hit_s     = capture_s && !count_legal_s;
    assign ovf_hit_s     = capture_s && count_legal_s && (fill_r == FILL_FULL) && !pop_s;
    assign rd_ptr_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

    // Occupancy after this edge's push/pop
    always_comb begin
        fill_next_s = fill_r;
        case ({push_s, pop_s})
            2'b10:   fill_next_s = fill_r + FILL_ONE;
            2'b01:   fill_next_s = fill_r - FILL_ONE;
            default: fill_next_s = fill_r;
        endcase
    end

    // Next head entry; a frame written into the slot that becomes the head bypasses storage
    always_comb begin
        head_next_s = ENTRY_ZERO;
        if (fill_next_s == FILL_ZERO) begin
            head_next_s = ENTRY_ZERO;
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = entry_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Next state; test_has_ended overrides every other transition
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CAPTURE: state_next_s = test_ending ? ST_FLUSH : ST_CAPTURE;
            ST_FLUSH:   state_next_s = (fill_r == FILL_ZERO) ? ST_DONE : ST_FLUSH;
            ST_DONE:    state_next_s = ST_DONE;
            ST_HALT:    state_next_s = ST_HALT;
            default:    state_next_s = ST_CAPTURE;
        endcase
        if (test_has_ended) begin
            state_next_s = ST_HALT;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Frame storage (intentionally not reset)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // State machine, pointers, registered read port and saturating counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_CAPTURE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            fill_r     <= FILL_ZERO;
            rd_data_r  <= ENTRY_ZERO;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            ovf_cnt_r  <= CNT_ZERO;
            err_cnt_r  <= CNT_ZERO;
        end else begin
            state_r    <= state_next_s;
            wr_ptr_r   <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r   <= rd_ptr_next_s;
            fill_r     <= fill_next_s;
            rd_data_r  <= head_next_s;
            rd_valid_r <= (fill_next_s != FILL_ZERO) && (state_next_s != ST_HALT);
            done_r     <= (state_next_s == ST_DONE) || (state_next_s == ST_HALT);
            if (ovf_hit_s && (ovf_cnt_r != CNT_MAX)) begin
                ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
            end
            if (err_hit_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
        end
    end

    assign trace.rd_data  = rd_data_r;
    assign trace.rd_valid = rd_valid_r;
    assign fill           = fill_r;
    assign overflow_cnt   = ovf_cnt_r;
    assign error_cnt      = err_cnt_r;
    assign state          = state_r;
    assign done           = done_r;
endmodule

// File: tb/tb_soc_system_cpu_oci_dct_monitor.sv
// Bench for the OCI data-trace monitor: directed scenarios plus a random
// phase, all checked every cycle against a queue-based reference model.
module tb_soc_system_cpu_oci_dct_monitor;
    localparam int FRAME_W = 30;
    localparam int COUNT_W = 4;
    localparam int SLOTS   = 3;
    localparam int DEPTH   = 16;
    localparam int OVF_W   = 8;
    localparam int CMAX    = (1 << OVF_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       test_ending = 1'b0;
    logic       test_has_ended = 1'b0;
    logic [4:0] fill;
    logic [7:0] overflow_cnt;
    logic [7:0] error_cnt;
    logic [1:0] state;
    logic       done;

    soc_system_cpu_oci_dct_monitor_if #(.FRAME_W(FRAME_W), .COUNT_W(COUNT_W)) bus ();

    soc_system_cpu_oci_dct_monitor #(
        .FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .SLOTS(SLOTS), .DEPTH(DEPTH), .OVF_W(OVF_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trace          (bus),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .fill           (fill),
        .overflow_cnt   (overflow_cnt),
        .error_cnt      (error_cnt),
        .state          (state),
        .done           (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: captured frames in arrival order, counters, state (0..3)
    logic [33:0] mq[$];
    int          m_st  = 0;
    int          m_ovf = 0;
    int          m_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit erv;
        erv = (mq.size() != 0) && (m_st != 3);
        chk({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(erv));
        if (erv) chk({tag, ".rd_data"}, 64'(bus.rd_data), 64'(mq[0]));
        chk({tag, ".fill"}, 64'(fill), 64'(mq.size()));
        chk({tag, ".overflow_cnt"}, 64'(overflow_cnt), 64'(m_ovf));
        chk({tag, ".error_cnt"}, 64'(error_cnt), 64'(m_err));
        chk({tag, ".state"}, 64'(state), 64'(m_st));
        chk({tag, ".done"}, 64'(done), 64'(m_st >= 2));
    endtask

    task automatic drive(input bit v, input int c, input logic [29:0] b, input bit r);
        bus.dct_valid  = v;
        bus.dct_count  = 4'(c);
        bus.dct_buffer = b;
        bus.rd_ready   = r;
    endtask

    // Apply one clock edge to DUT and model, then compare everything
    task automatic step(input string tag);
        bit rv, pop, cap, legal, push;
        int nst;
        logic [33:0] ent;
        rv    = (mq.size() != 0) && (m_st != 3);
        pop   = rv && bus.rd_ready;
        cap   = bus.dct_valid && (m_st == 0);
        legal = (int'(bus.dct_count) >= 1) && (int'(bus.dct_count) <= SLOTS);
        push  = cap && legal && ((mq.size() < DEPTH) || pop);
        nst   = m_st;
        if (m_st == 0 && test_ending) nst = 1;
        else if (m_st == 1 && mq.size() == 0) nst = 2;
        if (test_has_ended) nst = 3;
        ent = {bus.dct_count, bus.dct_buffer};
        if (cap && !legal && m_err < CMAX) m_err++;
        if (cap && legal && !push && m_ovf < CMAX) m_ovf++;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(ent);
        m_st = nst;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 30'h0, 1'b0);
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        reset_n        = 1'b0;
        #2;
        chk("rst.rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst.rd_data", 64'(bus.rd_data), 64'd0);
        chk("rst.fill", 64'(fill), 64'd0);
        chk("rst.overflow_cnt", 64'(overflow_cnt), 64'd0);
        chk("rst.error_cnt", 64'(error_cnt), 64'd0);
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        mq.delete();
        m_st  = 0;
        m_ovf = 0;
        m_err = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] e;
        drive(1'b0, 0, 30'h0, 1'b0);
        #1;
        do_reset();

        // Three frames held, then read out in order
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, i, 30'(i), 1'b0);
            step("t1_wr");
        end
        drive(1'b0, 0, 30'h0, 1'b0);
        chk("t1_fill3", 64'(fill), 64'd3);
        bus.rd_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            e = {4'(i), 30'(i)};
            chk("t1_rd", 64'(bus.rd_data), 64'(e));
            step("t1_pop");
        end
        chk("t1_empty_valid", 64'(bus.rd_valid), 64'd0);
        chk("t1_empty_fill", 64'(fill), 64'd0);

        // Twenty frames into a 16-deep FIFO without draining
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, int'($urandom_range(1, 3)), 30'($urandom), 1'b0);
            step("t2_fill");
        end
        chk("t2_full", 64'(fill), 64'd16);
        chk("t2_ovf", 64'(overflow_cnt), 64'd4);

        // Push and pop together while full, across pointer wrap
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, int'($urandom_range(1, 3)), 30'($urandom), 1'b1);
            step("t3_pushpop");
            chk("t3_fill", 64'(fill), 64'd16);
            chk("t3_ovf", 64'(overflow_cnt), 64'd4);
        end
        drive(1'b0, 0, 30'h0, 1'b1);
        for (int k = 0; k < 40 && bus.rd_valid; k++) step("t3_drain");
        chk("t3_drained", 64'(fill), 64'd0);

        // Illegal counts are rejected and counted
        do_reset();
        drive(1'b1, 1, 30'h11, 1'b0); step("t4_wr");
        drive(1'b1, 3, 30'h22, 1'b0); step("t4_wr");
        drive(1'b1, 0, 30'h33, 1'b0); step("t4_cnt0");
        drive(1'b1, 4, 30'h44, 1'b0); step("t4_cnt4");
        chk("t4_err", 64'(error_cnt), 64'd2);
        chk("t4_fill", 64'(fill), 64'd2);
        chk("t4_ovf", 64'(overflow_cnt), 64'd0);

        // Random traffic in CAPTURE
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 5)), 30'($urandom),
                  1'($urandom_range(0, 1)));
            step("rand");
        end

        // Flush: extra frame ignored, DONE one cycle after fill reaches 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2, 30'($urandom), 1'b0);
            step("t5_wr");
        end
        drive(1'b0, 0, 30'h0, 1'b0);
        test_ending = 1'b1;
        step("t5_end");
        chk("t5_flush", 64'(state), 64'd1);
        test_ending = 1'b0;
        drive(1'b1, 2, 30'h55, 1'b0);
        step("t5_extra");
        chk("t5_extra_fill", 64'(fill), 64'd5);
        chk("t5_extra_err", 64'(error_cnt), 64'd0);
        drive(1'b0, 0, 30'h0, 1'b1);
        for (int k = 0; k < 40 && fill != 5'd0; k++) step("t5_drain");
        chk("t5_fill0", 64'(fill), 64'd0);
        chk("t5_still_flush", 64'(state), 64'd1);
        step("t5_done");
        chk("t5_state_done", 64'(state), 64'd2);
        chk("t5_done", 64'(done), 64'd1);
        drive(1'b1, 1, 30'h66, 1'b1);
        step("t5_after_done");
        chk("t5_after_done_fill", 64'(fill), 64'd0);

        // Halt has priority over flush; contents frozen
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3, 30'($urandom), 1'b0);
            step("t6_wr");
        end
        drive(1'b0, 0, 30'h0, 1'b0);
        test_ending    = 1'b1;
        test_has_ended = 1'b1;
        step("t6_halt");
        chk("t6_state", 64'(state), 64'd3);
        chk("t6_rv", 64'(bus.rd_valid), 64'd0);
        chk("t6_fill", 64'(fill), 64'd3);
        bus.rd_ready = 1'b1;
        step("t6_frozen");
        chk("t6_frozen_fill", 64'(fill), 64'd3);
        do_reset();

        // Counter saturation
        for (int i = 0; i < DEPTH + 260; i++) begin
            drive(1'b1, 1, 30'($urandom), 1'b0);
            step("t7_ovf");
        end
        chk("t7_ovf_sat", 64'(overflow_cnt), 64'd255);
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, (i % 2 == 0) ? 0 : 9, 30'($urandom), 1'b0);
            step("t7_err");
        end
        chk("t7_err_sat", 64'(error_cnt), 64'd255);
        chk("t7_ovf_hold", 64'(overflow_cnt), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
